// File: rtl/gray_word_packer.sv
// Packs a stream of 8-bit gray pixels into little-endian 32-bit words and
// queues them in a first-word-fall-through FIFO for a DMA consumer.
module gray_word_packer #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        grayValid,
  input  logic [7:0]  grayPixel,
  input  logic        frameStart,
  input  logic        lineEnd,
  output logic        wordValid,
  output logic [31:0] wordData,
  input  logic        wordReady,
  output logic        overflow,
  output logic [15:0] wordCount
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {LANE0, LANE1, LANE2, LANE3} lane_e;

  lane_e        lane_q, lane_d, lane_cur;
  logic [23:0]  acc_q, acc_d, acc_cur;
  logic [31:0]  word;
  logic         pend_q, pend_d;
  logic [31:0]  pend_data_q, pend_data_d;
  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic [31:0]  mem_q [FIFO_DEPTH];
  logic         ovf_q, ovf_d;
  logic [15:0]  cnt_q, cnt_d;
  logic         empty, full, pop, push_acc, bypass, wr_en, rd_en, drop;

  // frameStart clears the packer before the same-cycle pixel is taken
  always_comb begin
    lane_cur    = frameStart ? LANE0 : lane_q;
    acc_cur     = frameStart ? 24'h0 : acc_q;
    word        = {8'h00, acc_cur};
    word[{lane_cur, 3'b000} +: 8] = grayPixel;
    lane_d      = lane_cur;
    acc_d       = acc_cur;
    pend_d      = 1'b0;
    pend_data_d = pend_data_q;
    if (grayValid) begin
      if (lane_cur == LANE3 || lineEnd) begin
        lane_d      = LANE0;
        acc_d       = 24'h0;
        pend_d      = 1'b1;
        pend_data_d = word;
      end else begin
        lane_d = lane_e'(lane_cur + 2'd1);
        acc_d  = word[23:0];
      end
    end
  end

  // A completed word waits one cycle in the pending stage before the push, so
  // a frameStart in that cycle still counts it. While the FIFO is empty the
  // pending word is shown directly at the head to keep latency at one cycle.
  always_comb begin
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    wordValid = !empty || pend_q;
    wordData  = empty ? pend_data_q : mem_q[rd_ptr_q[AW-1:0]];
    pop       = wordValid && wordReady;
    push_acc  = pend_q && (!full || pop);
    bypass    = empty && pop;
    wr_en     = push_acc && !bypass;
    rd_en     = pop && !empty;
    drop      = pend_q && !push_acc;
    cnt_d     = (frameStart ? 16'h0 : cnt_q) + {15'h0, push_acc};
    ovf_d     = (frameStart ? 1'b0 : ovf_q) | drop;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lane_q      <= LANE0;
      acc_q       <= 24'h0;
      pend_q      <= 1'b0;
      pend_data_q <= 32'h0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= 16'h0;
    end else begin
      lane_q      <= lane_d;
      acc_q       <= acc_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      wr_ptr_q    <= wr_ptr_q + {{AW{1'b0}}, wr_en};
      rd_ptr_q    <= rd_ptr_q + {{AW{1'b0}}, rd_en};
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && wr_en) mem_q[wr_ptr_q[AW-1:0]] <= pend_data_q;
  end

  assign overflow  = ovf_q;
  assign wordCount = cnt_q;
endmodule

// File: tb/tb_gray_word_packer.sv
// Directed scoreboard bench for gray_word_packer: stimulus pushes expected
// words, a negedge monitor pops and compares on every handshake.
module tb_gray_word_packer;
  localparam int D = 4;

  logic        clock = 1'b0;
  logic        reset, grayValid, frameStart, lineEnd, wordReady;
  logic [7:0]  grayPixel;
  logic        wordValid, overflow;
  logic [31:0] wordData;
  logic [15:0] wordCount;

  int checks = 0;
  int passes = 0;
  int npop   = 0;
  logic [31:0] exp_q[$];

  gray_word_packer #(.FIFO_DEPTH(D)) dut (
    .clock(clock), .reset(reset), .grayValid(grayValid), .grayPixel(grayPixel),
    .frameStart(frameStart), .lineEnd(lineEnd), .wordValid(wordValid),
    .wordData(wordData), .wordReady(wordReady), .overflow(overflow),
    .wordCount(wordCount)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  always @(negedge clock) begin
    if (!reset && wordValid && wordReady) begin
      npop++;
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL pop_unexpected: got %h expected none", wordData);
      end else begin
        check("pop_data", wordData, exp_q.pop_front());
      end
    end
  end

  task automatic px(input logic [7:0] p, input bit le = 1'b0, input bit fs = 1'b0);
    grayValid = 1'b1; grayPixel = p; lineEnd = le; frameStart = fs;
    @(posedge clock); #1;
    grayValid = 1'b0; lineEnd = 1'b0; frameStart = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic fs_only();
    frameStart = 1'b1;
    @(posedge clock); #1;
    frameStart = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; grayValid = 1'b0; grayPixel = 8'h00; frameStart = 1'b0;
    lineEnd = 1'b0; wordReady = 1'b0;
    idle(3);
    check("rst_valid", {31'b0, wordValid}, 32'd0);
    check("rst_ovf", {31'b0, overflow}, 32'd0);
    check("rst_cnt", {16'b0, wordCount}, 32'd0);
    reset = 1'b0;

    // four pixels -> one word, visible one cycle after the last pixel
    wordReady = 1'b1;
    exp_q.push_back(32'h44332211);
    px(8'h11); px(8'h22); px(8'h33);
    check("pre_valid", {31'b0, wordValid}, 32'd0);
    px(8'h44);
    check("lat_valid", {31'b0, wordValid}, 32'd1);
    idle(1);
    check("cnt_one", {16'b0, wordCount}, 32'd1);
    check("drained", {31'b0, wordValid}, 32'd0);

    // lineEnd zero-pads, next pixel restarts at byte 0
    exp_q.push_back(32'h0000BBAA);
    exp_q.push_back(32'hFFEEDDCC);
    px(8'hAA); px(8'hBB, 1'b1);
    px(8'hCC); px(8'hDD); px(8'hEE); px(8'hFF);
    idle(2);
    check("cnt_three", {16'b0, wordCount}, 32'd3);

    // overflow: D+1 words with consumer stalled
    fs_only();
    wordReady = 1'b0;
    for (int k = 0; k <= D; k++) begin
      logic [7:0] b;
      b = 8'(4 * k + 1);
      if (k < D) exp_q.push_back({b + 8'd3, b + 8'd2, b + 8'd1, b});
      px(b); px(b + 8'd1); px(b + 8'd2); px(b + 8'd3);
    end
    idle(2);
    check("ovf_set", {31'b0, overflow}, 32'd1);
    check("ovf_cnt", {16'b0, wordCount}, D);
    check("ovf_valid", {31'b0, wordValid}, 32'd1);
    npop = 0;
    wordReady = 1'b1;
    idle(D + 2);
    check("ovf_drain_n", npop, D);
    check("ovf_empty", {31'b0, wordValid}, 32'd0);
    check("ovf_sticky", {31'b0, overflow}, 32'd1);

    // full FIFO, push coincides with pop
    fs_only();
    check("fs_ovf_clr", {31'b0, overflow}, 32'd0);
    wordReady = 1'b0;
    for (int k = 0; k < D; k++) begin
      logic [7:0] b;
      b = 8'(8'h80 + 4 * k);
      exp_q.push_back({b + 8'd3, b + 8'd2, b + 8'd1, b});
      px(b); px(b + 8'd1); px(b + 8'd2); px(b + 8'd3);
    end
    idle(2);
    check("full_cnt", {16'b0, wordCount}, D);
    exp_q.push_back(32'hC4C3C2C1);
    px(8'hC1); px(8'hC2); px(8'hC3); px(8'hC4);
    wordReady = 1'b1;
    idle(1);
    wordReady = 1'b0;
    check("fp_ovf", {31'b0, overflow}, 32'd0);
    check("fp_cnt", {16'b0, wordCount}, D + 1);
    npop = 0;
    wordReady = 1'b1;
    idle(D + 2);
    check("fp_occ", npop, D);

    // frameStart with a pixel: partial dropped, pixel becomes lane 0
    px(8'h01); px(8'h02); px(8'h03);
    exp_q.push_back(32'h88776655);
    px(8'h55, 1'b0, 1'b1); px(8'h66); px(8'h77); px(8'h88);
    idle(2);
    check("fsp_ovf", {31'b0, overflow}, 32'd0);
    check("fsp_cnt", {16'b0, wordCount}, 32'd1);

    // word completed the cycle before frameStart counts in the new frame
    exp_q.push_back(32'hA4A3A2A1);
    px(8'hA1); px(8'hA2); px(8'hA3); px(8'hA4);
    fs_only();
    check("fsb_cnt", {16'b0, wordCount}, 32'd1);
    idle(2);

    // reset with queued and partial words loses everything
    wordReady = 1'b0;
    px(8'h10); px(8'h20); px(8'h30); px(8'h40);
    px(8'h50); px(8'h60); px(8'h70); px(8'h80);
    px(8'h90); px(8'h91);
    idle(1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check("rr_valid", {31'b0, wordValid}, 32'd0);
    check("rr_cnt", {16'b0, wordCount}, 32'd0);
    check("rr_ovf", {31'b0, overflow}, 32'd0);
    wordReady = 1'b1;
    exp_q.push_back(32'h04030201);
    px(8'h01); px(8'h02); px(8'h03); px(8'h04);
    idle(3);
    check("rr_cnt2", {16'b0, wordCount}, 32'd1);
    check("sb_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
